// File: rtl/lfsr_prbs_stream_if.sv
// ---------------------------------------------------------------------------
// lfsr_prbs_stream_if
//
// Purpose: bundles the control inputs and the output stream of
// lfsr_prbs_stream so the generator and its user share a single port.
//
// Handshake: a chunk moves from the generator to the consumer on a rising
// clock edge where out_valid and out_ready are both high. While out_valid is
// high and out_ready is low, out_data stays stable until it is accepted.
// out_valid never depends combinationally on out_ready.
//
// Signals (master = the block's user, slave = the generator):
//   load       user -> gen   synchronous seed-load strobe
//   seed       user -> gen   value loaded on load
//   taps       user -> gen   tap mask, used by every step
//   mode       user -> gen   0 = Fibonacci, 1 = Galois
//   en         user -> gen   run enable
//   out_ready  user -> gen   consumer accepts the current chunk
//   out_valid  gen  -> user  chunk available
//   out_data   gen  -> user  chunk, bit 0 = earliest bit
//   lfsr_state gen  -> user  current state register
//   lockup     gen  -> user  all-zero state detected
//   chunk_cnt  gen  -> user  chunks accepted since reset/load
//   fsm_state  gen  -> user  debug view of the control FSM
// ---------------------------------------------------------------------------
interface lfsr_prbs_stream_if #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int CNT_W = 32
);
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] taps;
    logic             mode;
    logic             en;
    logic             out_ready;
    logic             out_valid;
    logic [STEP-1:0]  out_data;
    logic [WIDTH-1:0] lfsr_state;
    logic             lockup;
    logic [CNT_W-1:0] chunk_cnt;
    logic [1:0]       fsm_state;

    modport master (
        output load, seed, taps, mode, en, out_ready,
        input  out_valid, out_data, lfsr_state, lockup, chunk_cnt, fsm_state
    );

    modport slave (
        input  load, seed, taps, mode, en, out_ready,
        output out_valid, out_data, lfsr_state, lockup, chunk_cnt, fsm_state
    );
endinterface

// File: rtl/lfsr_prbs_stream.sv
// ---------------------------------------------------------------------------
// lfsr_prbs_stream
//
// Purpose: PRBS generator producing STEP bits per clock from a WIDTH-bit LFSR
// in either Fibonacci or Galois form (selected at run time), delivered as a
// registered valid/ready stream. Seeds are loaded by strobe and an all-zero
// state is flagged as lock-up.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  lfsr_prbs_stream_if.slave (controls, output stream, status, FSM debug)
//
// Parameters: WIDTH (>=3), STEP (1..WIDTH), SEED_DEFAULT (nonzero reset
// state), CNT_W (accepted-chunk counter width).
//
// Optional build macro: LFSR_AUTO_RESEED_EN. When defined, a zero state is
// replaced by SEED_DEFAULT on the following cycle with a one-cycle lockup
// pulse instead of parking in LOCKED.
// ---------------------------------------------------------------------------
module lfsr_prbs_stream #(
    parameter int               WIDTH        = 16,
    parameter int               STEP         = 1,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
    parameter int               CNT_W        = 32
) (
    input logic               clk,
    input logic               rst,
    lfsr_prbs_stream_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [STEP-1:0]  out_data_q, out_data_d;
    logic             lockup_q, lockup_d;
    logic [CNT_W-1:0] chunk_cnt_q, chunk_cnt_d;

    logic [WIDTH-1:0] walk;       // state threaded through the STEP chained steps
    logic [WIDTH-1:0] state_adv;  // state after a full chunk
    logic [STEP-1:0]  chunk;
    logic             adv;
    logic             accept;
    logic             zero_state;

    // One LFSR step; the emitted bit is s[0] in both forms.
    function automatic logic [WIDTH-1:0] lfsr_step(
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] t,
        input logic             galois
    );
        if (galois) begin
            return {1'b0, s[WIDTH-1:1]} ^ (s[0] ? t : '0);
        end
        return {^(t & s), s[WIDTH-1:1]};
    endfunction

    // Unrolled chain of STEP steps straight from the state register.
    always_comb begin
        walk  = state_q;
        chunk = '0;
        for (int i = 0; i < STEP; i++) begin
            chunk[i] = walk[0];
            walk     = lfsr_step(walk, bus.taps, bus.mode);
        end
        state_adv = walk;
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        lockup_d    = lockup_q;
        chunk_cnt_d = chunk_cnt_q;

        zero_state = (state_q == '0);
        accept     = out_valid_q && bus.out_ready;
        // A zero state is diverted to lock-up handling rather than stepped.
        adv        = (fsm_q == ST_RUN) && bus.en && (!out_valid_q || bus.out_ready)
                     && !zero_state;

        if (bus.load) begin
            // Load wins over everything: any pending chunk is discarded.
            chunk_cnt_d = '0;
            out_valid_d = 1'b0;
            if (bus.seed == '0) begin
`ifdef LFSR_AUTO_RESEED_EN
                state_d  = SEED_DEFAULT;
                lockup_d = 1'b1;
                fsm_d    = bus.en ? ST_RUN : ST_IDLE;
`else
                state_d  = '0;
                lockup_d = 1'b1;
                fsm_d    = ST_LOCKED;
`endif
            end else begin
                state_d  = bus.seed;
                lockup_d = 1'b0;
                fsm_d    = bus.en ? ST_RUN : ST_IDLE;
            end
        end else begin
`ifdef LFSR_AUTO_RESEED_EN
            // lockup is a single-cycle pulse in this build.
            lockup_d = 1'b0;
`endif
            if (accept) begin
                chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
            end

            if (adv) begin
                out_data_d  = chunk;
                out_valid_d = 1'b1;
                state_d     = state_adv;
            end else if (accept) begin
                out_valid_d = 1'b0;
            end

            // Zero can arrive via non-primitive taps; checked in IDLE too so a
            // stream that stops right after reaching zero is still flagged.
            if ((fsm_q != ST_LOCKED) && zero_state) begin
                out_valid_d = 1'b0;
`ifdef LFSR_AUTO_RESEED_EN
                state_d  = SEED_DEFAULT;
                lockup_d = 1'b1;
                fsm_d    = bus.en ? ST_RUN : ST_IDLE;
`else
                lockup_d = 1'b1;
                fsm_d    = ST_LOCKED;
`endif
            end else begin
                case (fsm_q)
                    ST_IDLE: begin
                        if (bus.en) begin
                            fsm_d = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!bus.en && (!out_valid_q || bus.out_ready)) begin
                            fsm_d = ST_IDLE;
                        end
                    end
                    ST_LOCKED: begin
                        out_valid_d = 1'b0;
                        lockup_d    = 1'b1;
                    end
                    default: begin
                        fsm_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            state_q     <= SEED_DEFAULT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            lockup_q    <= 1'b0;
            chunk_cnt_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            lockup_q    <= lockup_d;
            chunk_cnt_q <= chunk_cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.lfsr_state = state_q;
    assign bus.lockup     = lockup_q;
    assign bus.chunk_cnt  = chunk_cnt_q;
    assign bus.fsm_state  = fsm_q;

endmodule

// File: tb/tb_lfsr_prbs_stream.sv
// ---------------------------------------------------------------------------
// tb_lfsr_prbs_stream
//
// Three generators share clock and reset:
//   a: WIDTH=4,  STEP=1  (Fibonacci/Galois periods, lock-up)
//   b: WIDTH=4,  STEP=4  (multi-bit chunks, backpressure, en drop)
//   c: WIDTH=16, STEP=3  (random seeds/taps/en/ready, reset defaults)
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lfsr_prbs_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    lfsr_prbs_stream_if #(.WIDTH(4),  .STEP(1), .CNT_W(32)) if_a ();
    lfsr_prbs_stream_if #(.WIDTH(4),  .STEP(4), .CNT_W(32)) if_b ();
    lfsr_prbs_stream_if #(.WIDTH(16), .STEP(3), .CNT_W(16)) if_c ();

    lfsr_prbs_stream #(.WIDTH(4), .STEP(1), .SEED_DEFAULT(4'h1), .CNT_W(32))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    lfsr_prbs_stream #(.WIDTH(4), .STEP(4), .SEED_DEFAULT(4'h1), .CNT_W(32))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    lfsr_prbs_stream #(.WIDTH(16), .STEP(3), .SEED_DEFAULT(16'h0001), .CNT_W(16))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    // Scoreboard for the random section: expected chunks and the state the
    // register holds once each chunk has been produced.
    logic [2:0]  exp_q[$];
    logic [15:0] exp_st_q[$];
    logic [15:0] idle_st, prev_state, s_m, rnd_taps, rnd_seed;
    logic [2:0]  prev_data;
    logic        prev_stall, rnd_mode;
    int          acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: n LFSR steps on a w-bit register, written arithmetically.
    function automatic logic [15:0] m_adv(input logic [15:0] s, input logic [15:0] t,
                                          input bit g, input int w, input int n);
        int fb;
        for (int i = 0; i < n; i++) begin
            if (g) begin
                s = (s >> 1) ^ (((s % 2) == 1) ? t : 16'h0);
            end else begin
                fb = $countones(s & t) % 2;
                s  = (s >> 1) | (16'(fb) << (w - 1));
            end
        end
        return s;
    endfunction

    // Reference: the n output bits (earliest in bit 0) produced from s.
    function automatic logic [15:0] m_bits(input logic [15:0] s, input logic [15:0] t,
                                           input bit g, input int w, input int n);
        logic [15:0] r;
        r = 16'h0;
        for (int i = 0; i < n; i++) begin
            r = r | (16'(s % 2) << i);
            s = m_adv(s, t, g, w, 1);
        end
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        if_a.load = 0; if_a.seed = 0; if_a.taps = 0; if_a.mode = 0; if_a.en = 0; if_a.out_ready = 0;
        if_b.load = 0; if_b.seed = 0; if_b.taps = 0; if_b.mode = 0; if_b.en = 0; if_b.out_ready = 0;
        if_c.load = 0; if_c.seed = 0; if_c.taps = 0; if_c.mode = 0; if_c.en = 0; if_c.out_ready = 0;
        repeat (2) @(negedge clk);

        // ---- reset values
        chk("rst_a_state", 32'(if_a.lfsr_state), 32'h1);
        chk("rst_a_valid", 32'(if_a.out_valid), 32'h0);
        chk("rst_a_data",  32'(if_a.out_data),  32'h0);
        chk("rst_a_lockup", 32'(if_a.lockup), 32'h0);
        chk("rst_a_cnt", 32'(if_a.chunk_cnt), 32'h0);
        chk("rst_c_state", 32'(if_c.lfsr_state), 32'h0001);
        rst = 1'b0;

        // ---- Fibonacci period, taps 0011, seed 0001
        @(negedge clk);
        if_a.taps = 4'b0011; if_a.mode = 1'b0; if_a.seed = 4'b0001;
        if_a.load = 1'b1; if_a.en = 1'b1; if_a.out_ready = 1'b1;
        @(negedge clk);
        if_a.load = 1'b0;
        chk("a_fib_loaded", 32'(if_a.lfsr_state), 32'h1);
        chk("a_fib_loaded_valid", 32'(if_a.out_valid), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("a_fib_state", 32'(if_a.lfsr_state), 32'(m_adv(16'h1, 16'h3, 1'b0, 4, k)));
            chk("a_fib_bit", 32'(if_a.out_data), 32'(m_adv(16'h1, 16'h3, 1'b0, 4, k - 1) % 2));
            chk("a_fib_valid", 32'(if_a.out_valid), 32'h1);
            if (k == 1)  chk("a_fib_first", 32'(if_a.lfsr_state), 32'h8);
            if (k == 15) chk("a_fib_period", 32'(if_a.lfsr_state), 32'h1);
            if (k == 16) chk("a_fib_cnt15", 32'(if_a.chunk_cnt), 32'd15);
        end

        // ---- Galois period, taps 1100, seed 0001
        if_a.taps = 4'b1100; if_a.mode = 1'b1; if_a.seed = 4'b0001; if_a.load = 1'b1;
        @(negedge clk);
        if_a.load = 1'b0;
        chk("a_gal_loaded", 32'(if_a.lfsr_state), 32'h1);
        chk("a_gal_cnt_clr", 32'(if_a.chunk_cnt), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("a_gal_state", 32'(if_a.lfsr_state), 32'(m_adv(16'h1, 16'hC, 1'b1, 4, k)));
            chk("a_gal_bit", 32'(if_a.out_data), 32'(m_adv(16'h1, 16'hC, 1'b1, 4, k - 1) % 2));
            if (k == 1)  chk("a_gal_first", 32'(if_a.lfsr_state), 32'hC);
            if (k == 14) chk("a_gal_14", 32'(if_a.lfsr_state), 32'h2);
            if (k == 15) chk("a_gal_period", 32'(if_a.lfsr_state), 32'h1);
        end

        // ---- multi-bit chunks and backpressure on b
        if_b.taps = 4'b0011; if_b.mode = 1'b0; if_b.seed = 4'b0001;
        if_b.load = 1'b1; if_b.en = 1'b1; if_b.out_ready = 1'b1;
        @(negedge clk);
        if_b.load = 1'b0; if_b.out_ready = 1'b0;
        @(negedge clk);
        chk("b_first_data", 32'(if_b.out_data), 32'h1);
        chk("b_first_state", 32'(if_b.lfsr_state), 32'h9);
        chk("b_first_valid", 32'(if_b.out_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("b_stall_data", 32'(if_b.out_data), 32'h1);
            chk("b_stall_state", 32'(if_b.lfsr_state), 32'h9);
            chk("b_stall_cnt", 32'(if_b.chunk_cnt), 32'h0);
            chk("b_stall_valid", 32'(if_b.out_valid), 32'h1);
        end
        if_b.out_ready = 1'b1;
        @(negedge clk);
        chk("b_release_cnt", 32'(if_b.chunk_cnt), 32'h1);
        chk("b_second_data", 32'(if_b.out_data), 32'h9);
        chk("b_second_state", 32'(if_b.lfsr_state), 32'(m_adv(16'h1, 16'h3, 1'b0, 4, 8)));
        @(negedge clk);
        chk("b_b2b_cnt", 32'(if_b.chunk_cnt), 32'h2);
        chk("b_b2b_valid", 32'(if_b.out_valid), 32'h1);
        chk("b_third_data", 32'(if_b.out_data),
            32'(m_bits(m_adv(16'h1, 16'h3, 1'b0, 4, 8), 16'h3, 1'b0, 4, 4)));
        chk("b_third_state", 32'(if_b.lfsr_state), 32'(m_adv(16'h1, 16'h3, 1'b0, 4, 12)));
        // en dropped with a chunk pending: it stays until accepted
        if_b.en = 1'b0; if_b.out_ready = 1'b0;
        @(negedge clk);
        chk("b_en0_hold_valid", 32'(if_b.out_valid), 32'h1);
        chk("b_en0_hold_data", 32'(if_b.out_data),
            32'(m_bits(m_adv(16'h1, 16'h3, 1'b0, 4, 8), 16'h3, 1'b0, 4, 4)));
        if_b.out_ready = 1'b1;
        @(negedge clk);
        chk("b_en0_accept_cnt", 32'(if_b.chunk_cnt), 32'h3);
        chk("b_en0_valid_drop", 32'(if_b.out_valid), 32'h0);
        @(negedge clk);
        chk("b_en0_idle_valid", 32'(if_b.out_valid), 32'h0);
        chk("b_en0_idle_state", 32'(if_b.lfsr_state), 32'(m_adv(16'h1, 16'h3, 1'b0, 4, 12)));

        // ---- lock-up via zero seed on a
        if_a.seed = 4'b0000; if_a.load = 1'b1; if_a.en = 1'b1; if_a.out_ready = 1'b1;
        @(negedge clk);
        if_a.load = 1'b0;
`ifdef LFSR_AUTO_RESEED_EN
        chk("a_zl_pulse", 32'(if_a.lockup), 32'h1);
        chk("a_zl_reseed", 32'(if_a.lfsr_state), 32'h1);
        chk("a_zl_valid", 32'(if_a.out_valid), 32'h0);
        @(negedge clk);
        chk("a_zl_pulse_end", 32'(if_a.lockup), 32'h0);
`else
        for (int k = 0; k < 4; k++) begin
            chk("a_zl_lockup", 32'(if_a.lockup), 32'h1);
            chk("a_zl_valid", 32'(if_a.out_valid), 32'h0);
            chk("a_zl_state", 32'(if_a.lfsr_state), 32'h0);
            @(negedge clk);
        end
`endif
        if_a.seed = 4'b0101; if_a.load = 1'b1;
        @(negedge clk);
        if_a.load = 1'b0;
        chk("a_zl_clear", 32'(if_a.lockup), 32'h0);
        chk("a_zl_cleared_state", 32'(if_a.lfsr_state), 32'h5);

        // ---- zero reached mid-run: Galois taps 0010 from 0101
        if_a.mode = 1'b1; if_a.taps = 4'b0010; if_a.seed = 4'b0101; if_a.load = 1'b1;
        @(negedge clk);
        if_a.load = 1'b0;
        @(negedge clk);
        chk("a_mz_state0", 32'(if_a.lfsr_state), 32'h0);
        chk("a_mz_valid", 32'(if_a.out_valid), 32'h1);
        @(negedge clk);
        chk("a_mz_lockup", 32'(if_a.lockup), 32'h1);
        chk("a_mz_valid_off", 32'(if_a.out_valid), 32'h0);
        chk("a_mz_cnt", 32'(if_a.chunk_cnt), 32'h1);
`ifdef LFSR_AUTO_RESEED_EN
        chk("a_mz_reseed", 32'(if_a.lfsr_state), 32'h1);
        @(negedge clk);
        chk("a_mz_pulse_end", 32'(if_a.lockup), 32'h0);
`else
        @(negedge clk);
        chk("a_mz_lockup_held", 32'(if_a.lockup), 32'h1);
        chk("a_mz_valid_held", 32'(if_a.out_valid), 32'h0);
`endif

        // ---- random segments on c against the chunk scoreboard
        for (int seg = 0; seg < 6; seg++) begin
            rnd_mode = 1'($urandom_range(0, 1));
            rnd_taps = 16'($urandom);
            // Keep the map invertible so a nonzero seed never reaches zero.
            if (rnd_mode) rnd_taps[15] = 1'b1;
            else          rnd_taps[0]  = 1'b1;
            rnd_seed = 16'($urandom_range(1, 65535));
            if_c.mode = rnd_mode; if_c.taps = rnd_taps; if_c.seed = rnd_seed;
            if_c.load = 1'b1; if_c.en = 1'b1; if_c.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if_c.load = 1'b0;
            exp_q.delete();
            exp_st_q.delete();
            s_m = rnd_seed;
            for (int i = 0; i < 150; i++) begin
                exp_q.push_back(3'(m_bits(s_m, rnd_taps, rnd_mode, 16, 3)));
                s_m = m_adv(s_m, rnd_taps, rnd_mode, 16, 3);
                exp_st_q.push_back(s_m);
            end
            idle_st = rnd_seed;
            acc = 0;
            prev_stall = 1'b0;
            prev_data = '0;
            prev_state = '0;
            for (int cyc = 0; cyc < 120; cyc++) begin
                chk("c_cnt", 32'(if_c.chunk_cnt), 32'(acc));
                chk("c_lockup", 32'(if_c.lockup), 32'h0);
                if (prev_stall) begin
                    chk("c_stall_valid", 32'(if_c.out_valid), 32'h1);
                    chk("c_stall_data", 32'(if_c.out_data), 32'(prev_data));
                    chk("c_stall_state", 32'(if_c.lfsr_state), 32'(prev_state));
                end
                if (if_c.out_valid) chk("c_state_pending", 32'(if_c.lfsr_state), 32'(exp_st_q[0]));
                else                chk("c_state_idle", 32'(if_c.lfsr_state), 32'(idle_st));
                if_c.en        = ($urandom_range(0, 3) != 0);
                if_c.out_ready = 1'($urandom_range(0, 1));
                if (if_c.out_valid && if_c.out_ready) begin
                    chk("c_chunk", 32'(if_c.out_data), 32'(exp_q.pop_front()));
                    idle_st = exp_st_q.pop_front();
                    acc++;
                end
                prev_stall = if_c.out_valid && !if_c.out_ready;
                prev_data  = if_c.out_data;
                prev_state = if_c.lfsr_state;
                @(negedge clk);
            end
            chk("c_progress", 32'(acc > 10), 32'h1);
        end

        // ---- asynchronous reset mid-run
        if_c.en = 1'b1; if_c.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_c_state", 32'(if_c.lfsr_state), 32'h0001);
        chk("arst_c_valid", 32'(if_c.out_valid), 32'h0);
        chk("arst_c_lockup", 32'(if_c.lockup), 32'h0);
        chk("arst_c_cnt", 32'(if_c.chunk_cnt), 32'h0);
        chk("arst_a_lockup", 32'(if_a.lockup), 32'h0);
        chk("arst_b_cnt", 32'(if_b.chunk_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_stream.md
Name: lfsr_prbs_stream

Overview:
- Parametrised successor to the team's single-mode shift-register LFSR.
- Runtime-selectable Fibonacci or Galois form, with STEP bits produced per clock.
- Output is a registered valid/ready stream; seed is loaded by explicit strobe; lock-up is detected.
- Feeds PRBS test-pattern insertion and scrambler paths downstream of the datapath.

Parameters:
WIDTH, 16, LFSR state width (>=3)
STEP, 1, output bits (LFSR steps) per accepted chunk, 1..WIDTH
SEED_DEFAULT, 1, state value after reset, must be nonzero
CNT_W, 32, width of accepted-chunk counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
load  in  1  synchronous seed-load strobe
seed  in  WIDTH  value loaded on load
taps  in  WIDTH  tap mask, sampled every step
mode  in  1  0 = Fibonacci, 1 = Galois, sampled every step
en  in  1  run enable
out_ready  in  1  downstream accepts chunk
out_valid  out  1  chunk available
out_data  out  STEP  chunk, bit 0 = earliest bit
lfsr_state  out  WIDTH  current state register
lockup  out  1  all-zero state detected
chunk_cnt  out  CNT_W  accepted chunks since reset/load, wraps

Behaviour:
- Reset (async, rst=1) sets:
  - state = SEED_DEFAULT, out_valid = 0, out_data = 0, lockup = 0, chunk_cnt = 0, FSM = IDLE.
- Single step from state s:
  - Output bit is s[0] in both modes.
  - Fibonacci: fb = XOR-reduce(taps & s); next = {fb, s[WIDTH-1:1]}.
  - Galois: next = {1'b0, s[WIDTH-1:1]} XOR (s[0] ? taps : 0).
- Chunk: STEP chained steps in one cycle, computed combinationally from the state register; out_data[i] = output bit of step i.
- Advance condition: adv = (state==RUN) && en && (!out_valid || out_ready).
- On adv:
  - out_data <= chunk; out_valid <= 1; state <= state after STEP steps.
  - Latency: first chunk is valid the cycle after the first adv edge.
- Acceptance:
  - out_valid && out_ready: chunk_cnt++ (wraps at 2^CNT_W).
  - If !adv, out_valid <= 0.
- Stall: out_valid && !out_ready holds out_data, out_valid and state stable.
- en = 0 with out_valid = 1: the chunk remains until accepted, then out_valid drops.
- FSM states: IDLE, RUN, LOCKED.
  - IDLE -> RUN when en = 1; RUN -> IDLE when en = 0 and no chunk is pending (out_valid = 0, or out_valid && out_ready).
  - RUN -> LOCKED when the state register is all-zero.
  - In LOCKED: lockup = 1, out_valid forced 0 next cycle, no advance.
- load (any FSM state, highest priority over adv/acceptance):
  - state <= seed; out_valid <= 0 (pending chunk discarded); chunk_cnt <= 0; lockup <= 0.
  - FSM -> RUN if en else IDLE.
  - load with seed == 0: state <= 0, FSM -> LOCKED next cycle, lockup = 1.
- mode/taps changes take effect on the next step; they never modify the state directly.
- A nonzero state that reaches zero (non-primitive taps in Galois) is also detected as lock-up.

Optional Feature:
LFSR_AUTO_RESEED_EN
- Defined:
  - LOCKED is never held; on detecting a zero state the block reloads SEED_DEFAULT the next cycle and pulses lockup for exactly one cycle.
  - It then returns to RUN if en, else IDLE; chunk_cnt is unaffected.
  - load with seed == 0 loads SEED_DEFAULT instead, with a one-cycle lockup pulse.
- Undefined: LOCKED behaviour exactly as in Behaviour.

Test Plan:
- Reset defaults: WIDTH=16, SEED_DEFAULT=1, assert rst mid-run -> lfsr_state=0x0001, out_valid=0, lockup=0, chunk_cnt=0 asynchronously.
- Fibonacci period: WIDTH=4, STEP=1, mode=0, taps=4'b0011, load seed 4'b0001, en=1, out_ready=1 -> states 0001,1000,0100,0010,1001,…,0011; state returns to 0001 after exactly 15 chunks; chunk_cnt=15.
- Galois period: WIDTH=4, mode=1, taps=4'b1100, seed 4'b0001 -> states 1100,0110,0011,1101,…,0010,0001; period 15.
- Multi-bit chunks: WIDTH=4, STEP=4, Fibonacci, taps=4'b0011, seed 0001 -> out_data 4'b0001 then 4'b1001; lfsr_state 1001 after first chunk.
- Backpressure: hold out_ready=0 for 5 cycles after first valid -> out_data, lfsr_state and chunk_cnt frozen; the release cycle accepts and the next chunk follows back-to-back.
- Lock-up: load seed=0 -> lockup=1, out_valid=0 held indefinitely; load seed=0x5 clears it. With LFSR_AUTO_RESEED_EN: single-cycle lockup pulse, then state=SEED_DEFAULT.
